isq_issue_arbiter: RTL and testbench

//  Shares one execution unit between NUM_REQ issue-queue dequeue ports.
//  - Grants one requester per cycle, round-robin.
//  - Registers the winner into a single-entry issue slot that feeds the unit.
//  - Kills slot contents younger than a flush ROB id, so no squashed op reaches the unit.

---
 rtl/isq_issue_arbiter.sv | 132 +++++++++++++
 tb/tb_isq_issue_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/isq_issue_arbiter.sv
// Round-robin issue arbiter: NUM_REQ issue-queue ports share one issue slot, with flush kill by ROB age.
// Optional ISQ_ARB_STARVE_GUARD_EN adds per-requester wait counters that force a grant after 15 waiting cycles.
module isq_issue_arbiter #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned REQ_LOG     = 1,
    parameter int unsigned DATA_WIDTH  = 248,
    parameter int unsigned ROBID_WIDTH = 7
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ*ROBID_WIDTH-1:0]  req_robid,
    output logic                            issue_valid,
    input  logic                            issue_ready,
    output logic [DATA_WIDTH-1:0]           issue_data,
    output logic [ROBID_WIDTH-1:0]          issue_robid,
    output logic [REQ_LOG-1:0]              issue_src,
    input  logic                            flush_valid,
    input  logic [ROBID_WIDTH-1:0]          flush_robid
);

    localparam int unsigned IDX_W = ROBID_WIDTH - 1;

    // Wrap bit flips the sense of the index compare; equal ids are not younger.
    function automatic logic younger(input logic [ROBID_WIDTH-1:0] e,
                                     input logic [ROBID_WIDTH-1:0] f);
        return (e[ROBID_WIDTH-1] ^ f[ROBID_WIDTH-1]) ^ (e[IDX_W-1:0] > f[IDX_W-1:0]);
    endfunction

    logic                   slot_valid;
    logic [DATA_WIDTH-1:0]  slot_data;
    logic [ROBID_WIDTH-1:0] slot_robid;
    logic [REQ_LOG-1:0]     slot_src;
    logic [REQ_LOG-1:0]     rr_ptr;

    logic                   slot_killed;
    logic                   can_load;
    logic                   grant_vld;
    logic [REQ_LOG-1:0]     grant_idx;
    logic [REQ_LOG-1:0]     scan_idx;
    logic [DATA_WIDTH-1:0]  grant_data;
    logic [ROBID_WIDTH-1:0] grant_robid;
    logic [REQ_LOG-1:0]     rr_next;

`ifdef ISQ_ARB_STARVE_GUARD_EN
    logic [3:0]             wait_cnt [NUM_REQ];
    logic                   starve_hit;
    logic [REQ_LOG-1:0]     starve_idx;
`endif

    assign slot_killed = slot_valid & flush_valid & younger(slot_robid, flush_robid);
    assign issue_valid = slot_valid & ~slot_killed;
    assign can_load    = ~slot_valid | (issue_valid & issue_ready) | slot_killed;

    assign issue_data  = slot_data;
    assign issue_robid = slot_robid;
    assign issue_src   = slot_src;

    // Grant search: rotate from rr_ptr, first valid requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
`ifdef ISQ_ARB_STARVE_GUARD_EN
        starve_hit = 1'b0;
        starve_idx = '0;
`endif
        if (reset_n && can_load && !flush_valid) begin
            for (int unsigned off = 0; off < NUM_REQ; off++) begin
                scan_idx = REQ_LOG'((32'(rr_ptr) + off) % NUM_REQ);
                if (!grant_vld && req_valid[scan_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = scan_idx;
                end
            end
`ifdef ISQ_ARB_STARVE_GUARD_EN
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!starve_hit && req_valid[i] && (wait_cnt[i] == 4'd15)) begin
                    starve_hit = 1'b1;
                    starve_idx = REQ_LOG'(i);
                end
            end
            if (starve_hit) begin
                grant_vld = 1'b1;
                grant_idx = starve_idx;
            end
`endif
        end
    end

    always_comb begin
        req_ready   = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
        grant_data  = req_data[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        grant_robid = req_robid[32'(grant_idx)*ROBID_WIDTH +: ROBID_WIDTH];
        rr_next     = REQ_LOG'((32'(grant_idx) + 32'd1) % NUM_REQ);
    end

    // Issue slot and round-robin pointer.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            slot_valid <= 1'b0;
            slot_data  <= '0;
            slot_robid <= '0;
            slot_src   <= '0;
            rr_ptr     <= '0;
        end else if (grant_vld) begin
            slot_valid <= 1'b1;
            slot_data  <= grant_data;
            slot_robid <= grant_robid;
            slot_src   <= grant_idx;
            rr_ptr     <= rr_next;
        end else if (can_load) begin
            slot_valid <= 1'b0;
        end
    end

`ifdef ISQ_ARB_STARVE_GUARD_EN
    // Wait counters saturate at 15 and clear on grant, flush or reset.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!reset_n || flush_valid || req_ready[i]) begin
                wait_cnt[i] <= 4'd0;
            end else if (req_valid[i] && (wait_cnt[i] != 4'd15)) begin
                wait_cnt[i] <= wait_cnt[i] + 4'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_isq_issue_arbiter.sv
// Directed bench for isq_issue_arbiter: reset, round-robin, backpressure, flush kill/keep and ROB wrap.
module tb_isq_issue_arbiter;

    localparam int unsigned NUM_REQ     = 2;
    localparam int unsigned REQ_LOG     = 1;
    localparam int unsigned DATA_WIDTH  = 248;
    localparam int unsigned ROBID_WIDTH = 7;

    logic                           clock = 1'b0;
    logic                           reset_n;
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0]  req_data;
    logic [NUM_REQ*ROBID_WIDTH-1:0] req_robid;
    logic                           issue_valid;
    logic                           issue_ready;
    logic [DATA_WIDTH-1:0]          issue_data;
    logic [ROBID_WIDTH-1:0]         issue_robid;
    logic [REQ_LOG-1:0]             issue_src;
    logic                           flush_valid;
    logic [ROBID_WIDTH-1:0]         flush_robid;

    int total = 0;
    int bad   = 0;

    localparam logic [DATA_WIDTH-1:0]  D0 = 248'hA0A0;
    localparam logic [DATA_WIDTH-1:0]  D1 = 248'hB1B1;
    localparam logic [ROBID_WIDTH-1:0] R0 = 7'h10;
    localparam logic [ROBID_WIDTH-1:0] R1 = 7'h11;

    isq_issue_arbiter #(
        .NUM_REQ(NUM_REQ), .REQ_LOG(REQ_LOG),
        .DATA_WIDTH(DATA_WIDTH), .ROBID_WIDTH(ROBID_WIDTH)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_robid(req_robid),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_data(issue_data), .issue_robid(issue_robid), .issue_src(issue_src),
        .flush_valid(flush_valid), .flush_robid(flush_robid)
    );

    always #5 clock = ~clock;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        req_valid   = '0;
        issue_ready = 1'b0;
        flush_valid = 1'b0;
        flush_robid = '0;
        req_data    = {D1, D0};
        req_robid   = {R1, R0};
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        req_valid   = 2'b11;
        issue_ready = 1'b0;
        flush_valid = 1'b0;
        flush_robid = '0;
        req_data    = {D1, D0};
        req_robid   = {R1, R0};
        tick();
        tick();
        #1;
        total++;
        if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
        total++;
        if (issue_valid !== 1'b0 || issue_robid !== 7'h00 || issue_src !== 1'b0) begin
            bad++; $display("FAIL reset_slot got v=%b rob=%h src=%0d exp v=0 rob=00 src=0", issue_valid, issue_robid, issue_src);
        end
        reset_n = 1'b1;
        #1;
        total++;
        if (req_ready !== 2'b01) begin bad++; $display("FAIL reset_first_grant got=%b exp=01", req_ready); end
        tick();
        #1;
        total++;
        if (issue_valid !== 1'b1 || issue_src !== 1'b0 || issue_robid !== R0 || issue_data !== D0) begin
            bad++; $display("FAIL reset_first_issue got v=%b src=%0d rob=%h exp v=1 src=0 rob=%h", issue_valid, issue_src, issue_robid, R0);
        end
        total++;
        if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_full_no_grant got=%b exp=00", req_ready); end
    endtask

    task automatic test_round_robin();
        logic [REQ_LOG-1:0]     exp_src;
        logic [NUM_REQ-1:0]     exp_rdy;
        logic [ROBID_WIDTH-1:0] exp_rob;
        do_reset();
        req_valid   = 2'b11;
        issue_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            exp_src = REQ_LOG'(i % 2);
            exp_rob = (i % 2 == 0) ? R0 : R1;
            exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
            total++;
            if (issue_valid !== 1'b1 || issue_src !== exp_src || issue_robid !== exp_rob) begin
                bad++; $display("FAIL rr_issue[%0d] got v=%b src=%0d rob=%h exp v=1 src=%0d rob=%h", i, issue_valid, issue_src, issue_robid, exp_src, exp_rob);
            end
            total++;
            if (req_ready !== exp_rdy) begin bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, req_ready, exp_rdy); end
        end
    endtask

    // Continues from the round-robin state: slot holds req 1, rr_ptr = 0.
    task automatic test_backpressure();
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (req_ready !== 2'b00 || issue_data !== D1 || issue_src !== 1'b1 || issue_valid !== 1'b1) begin
                bad++; $display("FAIL bp_hold[%0d] got rdy=%b src=%0d v=%b data=%h exp rdy=00 src=1 v=1 data=%h", i, req_ready, issue_src, issue_valid, issue_data, D1);
            end
            tick();
        end
        issue_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 2'b01) begin bad++; $display("FAIL bp_release_grant got=%b exp=01", req_ready); end
        tick();
        #1;
        total++;
        if (issue_src !== 1'b0 || issue_data !== D0) begin
            bad++; $display("FAIL bp_next_issue got src=%0d data=%h exp src=0 data=%h", issue_src, issue_data, D0);
        end
    endtask

    task automatic test_flush(input logic [ROBID_WIDTH-1:0] slot_id,
                              input logic [ROBID_WIDTH-1:0] flush_id,
                              input logic                   exp_keep);
        do_reset();
        req_robid = {R1, slot_id};
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        #1;
        total++;
        if (issue_valid !== 1'b1 || issue_robid !== slot_id) begin
            bad++; $display("FAIL flush_load[%h] got v=%b rob=%h exp v=1 rob=%h", slot_id, issue_valid, issue_robid, slot_id);
        end
        req_valid   = 2'b11;
        flush_valid = 1'b1;
        flush_robid = flush_id;
        #1;
        total++;
        if (issue_valid !== exp_keep) begin
            bad++; $display("FAIL flush_cycle[%h/%h] got v=%b exp v=%b", slot_id, flush_id, issue_valid, exp_keep);
        end
        total++;
        if (req_ready !== 2'b00) begin bad++; $display("FAIL flush_no_grant[%h/%h] got=%b exp=00", slot_id, flush_id, req_ready); end
        tick();
        flush_valid = 1'b0;
        req_valid   = '0;
        #1;
        total++;
        if (issue_valid !== exp_keep) begin
            bad++; $display("FAIL flush_after[%h/%h] got v=%b exp v=%b", slot_id, flush_id, issue_valid, exp_keep);
        end
        req_robid = {R1, R0};
    endtask

`ifdef ISQ_ARB_STARVE_GUARD_EN
    task automatic test_starve_guard();
        do_reset();
        req_valid = 2'b10;
        tick();
        issue_ready = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        req_valid   = 2'b11;
        issue_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 2'b10) begin bad++; $display("FAIL starve_override got=%b exp=10", req_ready); end
        tick();
        #1;
        total++;
        if (issue_src !== 1'b1) begin bad++; $display("FAIL starve_issue got src=%0d exp=1", issue_src); end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_flush(7'h05, 7'h03, 1'b0);
        test_flush(7'h03, 7'h03, 1'b1);
        test_flush(7'h41, 7'h3E, 1'b0);
        test_flush(7'h3E, 7'h41, 1'b1);
`ifdef ISQ_ARB_STARVE_GUARD_EN
        test_starve_guard();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
